// File: rtl/debug_uart_transceiver.sv
// 8N1 debug UART: RX (2-flop synchronised, mid-bit sampling) and TX sharing one clock and reset.
// Define DEBUG_UART_LOOPBACK_EN to feed the TX line into the RX path for self-test.
module debug_uart_transceiver #(
  parameter int unsigned TICKS_PER_BIT      = 1146,
  parameter int unsigned TICKS_PER_BIT_SIZE = 11
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_enable,
  input  logic       i_din_priortobuffer,
  output logic [7:0] o_rxdata,
  output logic       o_recvdata,
  output logic       o_rx_busy,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_dout
);

  typedef logic [TICKS_PER_BIT_SIZE-1:0] tick_t;
  localparam tick_t TickLast = tick_t'(TICKS_PER_BIT - 1);
  localparam tick_t TickHalf = tick_t'(TICKS_PER_BIT / 2);

  typedef enum logic [4:0] {
    RxIdle  = 5'b00001,
    RxStart = 5'b00010,
    RxData  = 5'b00100,
    RxStop  = 5'b01000,
    RxDone  = 5'b10000
  } rx_state_e;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  rx_state_e  rx_state_q, rx_state_d;
  tick_t      rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_armed_q, rx_armed_d;
  logic       rx_meta_q, rx_sync_q, rx_line;

  tx_state_e  tx_state_q, tx_state_d;
  tick_t      tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_dout_q, tx_dout_d;
  logic       tx_done_q, tx_done_d;

`ifdef DEBUG_UART_LOOPBACK_EN
  logic unused_din;
  assign unused_din = i_din_priortobuffer;
  assign rx_line    = tx_dout_q;
`else
  assign rx_line    = i_din_priortobuffer;
`endif

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_armed_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_line;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_armed_q <= rx_armed_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_armed_d = rx_armed_q;
    unique case (rx_state_q)
      RxIdle: begin
        // After a framing error the line must be seen high before a new start is accepted.
        if (rx_sync_q) rx_armed_d = 1'b1;
        if (i_enable && rx_armed_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == TickHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + tick_t'(1);
        end
      end
      RxData: begin
        if (rx_cnt_q == TickLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + tick_t'(1);
        end
      end
      RxStop: begin
        if (rx_cnt_q == TickLast) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_state_d = RxDone;
          end else begin
            rx_armed_d = 1'b0;
            rx_state_d = RxIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + tick_t'(1);
        end
      end
      RxDone:  rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  assign o_rxdata   = rx_data_q;
  assign o_recvdata = (rx_state_q == RxDone);
  assign o_rx_busy  = (rx_state_q != RxIdle);

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_dout_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_dout_q  <= tx_dout_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_dout_d  = tx_dout_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (i_start) begin
          tx_shift_d = i_data;
          tx_dout_d  = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == TickLast) begin
          tx_cnt_d   = '0;
          tx_dout_d  = tx_shift_q[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + tick_t'(1);
        end
      end
      TxData: begin
        if (tx_cnt_q == TickLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_dout_d  = 1'b1;
            tx_state_d = TxStop;
          end else begin
            // Bit 0 of the shift register is always the bit currently on the line.
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_dout_d  = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + tick_t'(1);
        end
      end
      TxStop: begin
        if (tx_cnt_q == TickLast) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = TxIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + tick_t'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign o_dout = tx_dout_q;
  assign o_done = tx_done_q;
  assign o_busy = (tx_state_q != TxIdle);

endmodule

// File: tb/tb_debug_uart_transceiver.sv
// Self-checking bench for debug_uart_transceiver at 16 ticks per bit.
module tb_debug_uart_transceiver;
  localparam int TPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       din = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] rxdata;
  logic       recvdata, rx_busy, done, busy, dout;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic [7:0] pulse_data = 8'h00;

  debug_uart_transceiver #(
    .TICKS_PER_BIT      (TPB),
    .TICKS_PER_BIT_SIZE (5)
  ) dut (
    .i_clk               (clk),
    .reset               (rst_n),
    .i_enable            (enable),
    .i_din_priortobuffer (din),
    .o_rxdata            (rxdata),
    .o_recvdata          (recvdata),
    .o_rx_busy           (rx_busy),
    .i_start             (start),
    .i_data              (data),
    .o_done              (done),
    .o_busy              (busy),
    .o_dout              (dout)
  );

  always #5 clk = ~clk;

  // Every cycle o_recvdata is high counts, so a pulse longer than one cycle shows as extra pulses.
  always @(negedge clk) begin
    if (rst_n && recvdata === 1'b1) begin
      pulse_cnt  = pulse_cnt + 1;
      pulse_data = rxdata;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accepting edge; ends #1 after the edge that should raise o_done.
  task automatic tx_watch(input logic [7:0] d, input bit poke);
    logic [9:0] frame;
    int bad;
    frame = {1'b1, d, 1'b0};
    bad = 0;
    check("tx_busy_after_accept", busy, 1'b1);
    for (int k = 0; k < 10 * TPB; k++) begin
      if (dout !== frame[k / TPB]) bad++;
      if (done !== 1'b0) bad++;
      if (busy !== 1'b1) bad++;
      if (poke && k == 70) start = 1'b1;
      if (poke && k == 71) start = 1'b0;
      step();
    end
    check("tx_wave", bad, 0);
    check("tx_done_pulse", done, 1'b1);
    check("tx_busy_clear", busy, 1'b0);
    check("tx_line_idle", dout, 1'b1);
  endtask

  task automatic tx_frame(input logic [7:0] d, input bit poke);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    step();
    start = 1'b0;
    data  = 8'($urandom);
    tx_watch(d, poke);
    step();
    check("tx_done_one_cycle", done, 1'b0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop_bit, output logic busy_mid);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    busy_mid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      din = bits[b];
      if (b == 5) busy_mid = rx_busy;
      repeat (TPB - 1) @(negedge clk);
    end
    @(negedge clk);
    din = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop_bit;
    logic       en;
    int         exp_pulses;
    logic [7:0] exp_data;
  } rx_vec_t;

  rx_vec_t rx_tab[5];

  initial begin
    logic       bm;
    logic [7:0] model_last;
    int         p0;

    rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1, 8'h3C};
    rx_tab[1] = '{8'h55, 1'b0, 1'b1, 0, 8'h3C};
    rx_tab[2] = '{8'h81, 1'b1, 1'b1, 1, 8'h81};
    rx_tab[3] = '{8'h00, 1'b1, 1'b0, 0, 8'h81};
    rx_tab[4] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_recvdata", recvdata, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_dout", dout, 1'b1);

    tx_frame(8'hA5, 1'b1);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 5)) step();
      tx_frame(8'($urandom), bit'($urandom_range(0, 1)));
    end

    // Held-high i_start: the next frame is accepted the cycle after o_done.
    @(negedge clk);
    start = 1'b1;
    data  = 8'hC3;
    step();
    data = 8'h96;
    tx_watch(8'hC3, 1'b0);
    step();
    start = 1'b0;
    check("b2b_dout_start", dout, 1'b0);
    tx_watch(8'h96, 1'b0);
    step();

`ifdef DEBUG_UART_LOOPBACK_EN
    p0 = pulse_cnt;
    @(negedge clk);
    start = 1'b1;
    data  = 8'h7E;
    step();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      din = 1'($urandom);
      step();
    end
    din = 1'b1;
    check("lb_pulses", pulse_cnt - p0, 1);
    check("lb_data", pulse_data, 8'h7E);
    check("lb_rxdata", rxdata, 8'h7E);
    check("lb_rx_busy", rx_busy, 1'b0);
`else
    for (int i = 0; i < 5; i++) begin
      p0 = pulse_cnt;
      enable = rx_tab[i].en;
      rx_frame(rx_tab[i].d, rx_tab[i].stop_bit, bm);
      enable = 1'b1;
      check("rx_tab_pulses", pulse_cnt - p0, rx_tab[i].exp_pulses);
      check("rx_tab_rxdata", rxdata, rx_tab[i].exp_data);
      check("rx_tab_busy_mid", bm, rx_tab[i].en);
      check("rx_tab_busy_end", rx_busy, 1'b0);
      if (rx_tab[i].exp_pulses == 1) check("rx_tab_pulse_data", pulse_data, rx_tab[i].exp_data);
    end

    // Short low glitch on an idle line.
    p0 = pulse_cnt;
    @(negedge clk);
    din = 1'b0;
    repeat (4) @(negedge clk);
    din = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_seen", rx_busy, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch_pulses", pulse_cnt - p0, 0);
    check("glitch_busy_end", rx_busy, 1'b0);

    model_last = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic       sb;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      p0 = pulse_cnt;
      rx_frame(d, sb, bm);
      if (sb) model_last = d;
      check("rx_rand_pulses", pulse_cnt - p0, sb ? 1 : 0);
      check("rx_rand_rxdata", rxdata, model_last);
    end
`endif

    // Reset mid-frame aborts TX and clears RX data.
    @(negedge clk);
    start = 1'b1;
    data  = 8'h00;
    step();
    start = 1'b0;
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rxdata", rxdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("after_rst_busy", busy, 1'b0);
    check("after_rst_dout", dout, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
